// File: rtl/csa_arb_pkg.sv
// Shared types and helpers for the carry-select-adder sharing arbiter.
package csa_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 64;
  localparam int IDW_MAX   = 3;  // enough for up to 8 requesters

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/csa_share_arb_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arb
  import csa_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/csa_share_arb.sv
// Shares one pipelined adder between NREQ requesters with round-robin issue.
// Define CSA_ARB_CNT_EN to add the issue_cnt / busy observation ports.
module csa_share_arb
  import csa_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADD_LAT = 1,
  parameter int IDW     = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
`ifdef CSA_ARB_CNT_EN
  ,
  output logic [31:0]           issue_cnt,
  output logic [0:0]            busy
`endif
);

  logic [IDW-1:0]  ptr, winner, ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic            hs;
  tag_t            tag_pipe [ADD_LAT+1];

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .winner (winner)
  );

  // Grant only ever lands on a valid requester, so any grant is a handshake.
  assign req_ready = gnt;
  assign hs        = |gnt;
  assign ptr_nxt   = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (hs) begin
      ptr     <= ptr_nxt;
      add_a   <= req_a[winner*WIDTH +: WIDTH];
      add_b   <= req_b[winner*WIDTH +: WIDTH];
      add_cin <= req_cin[winner];
    end
  end

  // Tags walk alongside the adder so the result is matched to its issuer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ADD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: hs, id: IDW_MAX'(winner)};
      for (int i = 1; i <= ADD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= tag_pipe[ADD_LAT].valid;
      if (tag_pipe[ADD_LAT].valid) begin
        rsp_id   <= tag_pipe[ADD_LAT].id[IDW-1:0];
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
    end
  end

`ifdef CSA_ARB_CNT_EN
  logic any_vld;

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i <= ADD_LAT; i++) any_vld = any_vld | tag_pipe[i].valid;
  end

  assign busy = any_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) issue_cnt <= '0;
    else if (hs && issue_cnt != 32'hFFFF_FFFF) issue_cnt <= issue_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_csa_share_arb.sv
// Randomized + directed bench for csa_share_arb against a queue-based reference model.
module tb_csa_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, req_cin;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]    add_a, add_b, add_sum, rsp_sum;
  logic            add_cin, add_cout, rsp_valid, rsp_cout;
  logic [IDW-1:0]  rsp_id;
`ifdef CSA_ARB_CNT_EN
  logic [31:0]     issue_cnt;
  logic [0:0]      busy;
`endif

  csa_share_arb #(.NREQ(NREQ), .WIDTH(W), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef CSA_ARB_CNT_EN
    , .issue_cnt(issue_cnt), .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  // External adder stand-in: one register stage.
  always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  typedef struct {
    int         due;
    int         id;
    logic [63:0] sum;
    logic       cout;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, ptr = 0, ncnt = 0;
  logic [63:0] la = 0, lb = 0, ers = 0;
  logic        lc = 0, ec = 0;
  int          eid = 0;
  int          glog[$], rid[$], rcyc[$];
  logic [63:0] rsum[$];
  logic        rcout[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qi(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic clear_logs();
    glog.delete(); rid.delete(); rcyc.delete(); rsum.delete(); rcout.delete();
  endtask

  // One clock: check at negedge against the model, then advance the model.
  task automatic cycle();
    logic [NREQ-1:0] eg;
    logic [64:0]     s;
    logic            ev, eb;
    int              w, idx;
    @(negedge clk);
    if (rst) begin
      q.delete(); ptr = 0; la = 0; lb = 0; lc = 0; ers = 0; eid = 0; ec = 0; ncnt = 0;
    end
    eg = '0; w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("req_ready", 65'(req_ready), 65'(eg));
    chk("add_a", 65'(add_a), 65'(la));
    chk("add_b", 65'(add_b), 65'(lb));
    chk("add_cin", 65'(add_cin), 65'(lc));
    eb = 1'b0;
    foreach (q[i]) if (q[i].due == cyc + 1 || q[i].due == cyc + 2) eb = 1'b1;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1; ers = q[0].sum; eid = q[0].id; ec = q[0].cout;
      void'(q.pop_front());
    end else ev = 1'b0;
    chk("rsp_valid", 65'(rsp_valid), 65'(ev));
    chk("rsp_id", 65'(rsp_id), 65'(eid));
    chk("rsp_sum", 65'(rsp_sum), 65'(ers));
    chk("rsp_cout", 65'(rsp_cout), 65'(ec));
`ifdef CSA_ARB_CNT_EN
    chk("busy", 65'(busy), 65'(eb));
    chk("issue_cnt", 65'(issue_cnt), 65'(ncnt));
`endif
    for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) glog.push_back(i);
    if (rsp_valid) begin
      rid.push_back(int'(rsp_id)); rcyc.push_back(cyc);
      rsum.push_back(rsp_sum); rcout.push_back(rsp_cout);
    end
    if (w >= 0 && !rst) begin
      la = req_a[w*W +: W]; lb = req_b[w*W +: W]; lc = req_cin[w];
      s  = {1'b0, la} + {1'b0, lb} + {64'd0, lc};
      q.push_back('{due: cyc + 3, id: w, sum: s[63:0], cout: s[64]});
      ptr = (w + 1) % NREQ;
      ncnt++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    repeat (2) cycle();
    rst = 1'b0;

    // single op on req 0: 2+5
    clear_logs(); t0 = cyc;
    set_op(0, 64'd2, 64'd5, 1'b0); req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t1_ngnt", 65'(glog.size()), 65'd1);
    chk("t1_nrsp", 65'(rid.size()), 65'd1);
    if (rid.size() == 1) begin
      chk("t1_lat", 65'(rcyc[0] - t0), 65'd3);
      chk("t1_sum", 65'(rsum[0]), 65'd7);
      chk("t1_cout", 65'(rcout[0]), 65'd0);
      chk("t1_id", 65'(rid[0]), 65'd0);
    end

    // all four held for 8 cycles after reset
    reset_dut(); clear_logs();
    for (int i = 0; i < NREQ; i++) set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    req_valid = 4'hF;
    repeat (8) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t2_nrsp", 65'(rid.size()), 65'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_gnt", 65'(qi(glog, i)), 65'(i % 4));
      chk("t2_id", 65'(qi(rid, i)), 65'(i % 4));
      chk("t2_cyc", 65'(qi(rcyc, i) - qi(rcyc, 0)), 65'(i));
    end

    // req 2: all-ones + 1 wraps with carry, then 12+12+1
    clear_logs();
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0); req_valid = 4'b0100;
    cycle();
    set_op(2, 64'd12, 64'd12, 1'b1);
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t3_nrsp", 65'(rid.size()), 65'd2);
    if (rid.size() == 2) begin
      chk("t3_sum0", 65'(rsum[0]), 65'd0);
      chk("t3_cout0", 65'(rcout[0]), 65'd1);
      chk("t3_id0", 65'(rid[0]), 65'd2);
      chk("t3_sum1", 65'(rsum[1]), 65'd25);
    end

    // pointer to 2, then reqs 1 and 3 contend, idle, then lone req 0
    clear_logs();
    req_valid = 4'b0010; cycle();
    req_valid = 4'b1010; cycle();
    req_valid = 4'b0010; cycle();
    req_valid = '0; repeat (5) cycle();
    req_valid = 4'b0001; cycle();
    req_valid = '0; repeat (4) cycle();
    chk("t4_gnt0", 65'(qi(glog, 0)), 65'd1);
    chk("t4_gnt1", 65'(qi(glog, 1)), 65'd3);
    chk("t4_gnt2", 65'(qi(glog, 2)), 65'd1);
    chk("t4_gnt3", 65'(qi(glog, 3)), 65'd0);

    // reset one cycle after three back-to-back issues
    clear_logs();
    req_valid = 4'b0111;
    repeat (3) cycle();
    req_valid = '0;
    rst = 1'b1; #1;
    chk("t5_rsp_valid", 65'(rsp_valid), 65'd0);
    chk("t5_add_a", 65'(add_a), 65'd0);
    chk("t5_add_b", 65'(add_b), 65'd0);
    chk("t5_rsp_sum", 65'(rsp_sum), 65'd0);
    chk("t5_rsp_id", 65'(rsp_id), 65'd0);
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk("t5_no_rsp", 65'(rid.size()), 65'd0);
    req_valid = 4'hF; cycle();
    req_valid = '0;
    chk("t5_first_gnt", 65'(qi(glog, 3)), 65'd0);
    repeat (4) cycle();

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      req_valid = 4'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      cycle();
      rst = 1'b0;
    end
    req_valid = '0;
    repeat (5) cycle();
    chk("rand_drained", 65'(q.size()), 65'd0);

`ifdef CSA_ARB_CNT_EN
    reset_dut();
    req_valid = 4'b0001;
    repeat (10) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("cnt_10", 65'(issue_cnt), 65'd10);
    chk("busy_idle", 65'(busy), 65'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_share_arb.md
Name: csa_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one external WIDTH-bit adder (the team's 64-bit carry-select adder) between NREQ requesters.
- Accepts operand triples (a, b, cin) over valid/ready and drives the shared adder's ports.
- Tracks in-flight operations through the adder's fixed latency.
- Returns each sum/carry tagged with the requester id.
- Sits between compute clients and the single adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/sum width.
- ADD_LAT, 1, cycles from add_a/add_b/add_cin stable to add_sum/add_cout valid (0 = combinational adder).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- req_a  in  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing.
- req_cin  in  NREQ  carry-in per requester.
- add_a  out  WIDTH  registered operand a to the shared adder.
- add_b  out  WIDTH  registered operand b to the shared adder.
- add_cin  out  1  registered carry-in to the shared adder.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  one-cycle result pulse; no backpressure.
- rsp_id  out  IDW  requester id of the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_cout  out  1  registered carry-out.

Behaviour:
- Reset, asynchronous: add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout = 0; rr pointer = 0; tag pipeline cleared. Deassertion is synchronous to clk.
- Arbitration, combinational in cycle T:
  - Search req_valid starting at the pointer and wrap modulo NREQ.
  - First set bit wins; req_ready is one-hot on the winner, all-zero when no req_valid.
  - req_ready does not depend on any ready from downstream.
  - One grant per cycle max.
- Pointer update on handshake only: pointer <= (winner+1) mod NREQ. It holds when idle.
- Launch: on handshake in T, add_a/add_b/add_cin <= winner operands, stable during T+1. With no handshake, add_* hold their previous values.
- Tag pipeline: ADD_LAT+1 stages of {valid, id}. Stage 0 is loaded with {handshake, winner} at the end of T.
- Capture: when the tag leaving the last stage is valid (add_sum valid in cycle T+1+ADD_LAT):
  - rsp_sum <= add_sum, rsp_cout <= add_cout, rsp_id <= tag id, rsp_valid <= 1.
  - Otherwise rsp_valid <= 0, and rsp_sum/id/cout hold.
- Latency: handshake cycle T to rsp_valid cycle T+ADD_LAT+2.
- Throughput: 1 op/cycle. Results return in issue order.
- Arithmetic: none in this block; sum = (a+b+cin) mod 2^WIDTH, cout = bit WIDTH, as produced by the adder.
- Boundary cases:
  - A requester holding req_valid while others are active waits at most NREQ-1 grants.
  - A single active requester is granted every cycle.
  - req_valid dropping without ready is legal and is ignored.
  - Reset mid-operation drops all in-flight ops; no rsp_valid for them after reset.

Optional Feature:
- Macro: CSA_ARB_CNT_EN.
- When defined:
  - Adds output issue_cnt [31:0], which increments on every handshake and saturates at 32'hFFFF_FFFF.
  - Adds output busy [0:0], high while any tag stage is valid.
  - Both reset to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package csa_arb_pkg:
  - function clog2.
  - Localparam defaults NREQ_DEF=4, WIDTH_DEF=64.
  - typedef tag_t {logic valid; logic [IDW-1:0] id}.
- One sub-module: rr_arb (NREQ). Inputs: req vector and pointer. Output: one-hot grant plus encoded winner. Combinational.
- Tag shift register and launch/capture registers stay in csa_share_arb.

Test Plan:
- Bench adder is a registered model with ADD_LAT=1. Only req 0 valid, a=2, b=5, cin=0 -> req_ready[0]=1 in T, add_a=2/add_b=5 in T+1, rsp_valid in T+3 with rsp_sum=7, rsp_cout=0, rsp_id=0.
- All 4 req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; 8 rsp pulses on consecutive cycles with ids in the same order.
- req 2 only: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> rsp_sum=0, rsp_cout=1, rsp_id=2. Then a=12, b=12, cin=1 -> rsp_sum=25.
- req 1 and req 3 valid, pointer at 2 -> req 3 granted first, then req 1. Pointer holds across 5 idle cycles, so the next lone req 0 is granted immediately.
- Issue 3 back-to-back ops, assert rst one cycle after the last handshake -> all outputs 0 immediately, no rsp_valid afterward, first post-reset request granted to req 0.
- With CSA_ARB_CNT_EN, 10 handshakes -> issue_cnt=10; busy is high from the first handshake+1 until the last rsp cycle, then 0.
